irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Multi-source interrupt arbiter that sits between peripheral interrupt lines and the pipeline control FSM's single `irq`/`iack` pair. It latches rising edges into a pending register, applies a software mask, and selects one fixed-priority winner. It presents the winner to the core as a level `irq`, then tracks the in-service source until the core returns.

## Interface
Parameters:
- `N_SRC`, 8, number of interrupt sources; index 0 is the highest priority.
- `ID_W`, 3, width of the vector id; 2^ID_W >= N_SRC is required.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `irq_src`  in  N_SRC  interrupt source levels, synchronous to `clk`; a 0→1 transition requests service.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_din`  in  N_SRC  new mask value; 1 = source enabled.
- `pend_clr`  in  N_SRC  write-1-to-clear strobes for pending bits, valid for one cycle.
- `iack`  in  1  level from the control FSM: high from IRQ entry until RET.
- `irq`  out  1  interrupt request to the control FSM; registered.
- `vec_id`  out  ID_W  index of the requested or in-service source; registered.
- `in_service`  out  1  high while a granted interrupt is being serviced.
- `pending`  out  N_SRC  raw pending register, unmasked.
- `mask`  out  N_SRC  current mask register.

## Operation
- Edge detect:
  - `src_q` is a 1-cycle delayed copy of `irq_src`; `rise = irq_src & ~src_q`.
  - `src_q` resets to 0, so a source held high across reset release registers as an edge on the first clock.
- Pending update, per bit:
  - `pending_next = rise | (pending & ~pend_clr & ~grant_clr)`.
  - A new edge wins over a simultaneous clear.
  - `grant_clr` is the one-hot of `vec_id`, asserted only on the REQ→SERV transition.
- Mask: `mask_we` loads `mask_din` at the clock edge. Masked sources still latch pending but are not arbitrated.
- Arbitration: `eligible = pending & mask`. The winner is the lowest set index of `eligible`, computed combinationally.
- FSM states:
  - IDLE: `irq`=0, `in_service`=0. If `eligible != 0` and `iack == 0`, go to REQ: load `vec_id` = winner and set `irq`=1.
  - REQ: `irq`=1 and `vec_id` frozen; no preemption by a later higher-priority edge. Transitions are evaluated in this order:
    - If the `vec_id` bit of `eligible` drops (masked or cleared by software) while `iack`=0, go to IDLE with `irq`=0.
    - Else on `iack`=1, go to SERV: `irq`=0, `in_service`=1, clear `pending[vec_id]`.
  - SERV: `irq`=0 and `vec_id` held. On `iack`=0, go to IDLE with `in_service`=0.
- `iack` high while in IDLE (core busy on a foreign entry) blocks requests; no state change.
- Reset (asynchronous, any state): state=IDLE, `irq`=0, `vec_id`=0, `in_service`=0, `pending`=0, `mask`=0, `src_q`=0.

## Timing
- Request latency:
  - Source rise first sampled at edge k → `pending` bit visible after edge k.
  - `irq`=1 and `vec_id` valid after edge k+1, provided the source is enabled and the FSM is in IDLE.
- Acknowledge:
  - `iack` sampled high at edge m → after edge m: `irq`=0, `in_service`=1, pending bit cleared.
  - `irq` and `iack` are never simultaneously high for more than one sampled cycle.
- Return:
  - `iack` sampled low at edge n → IDLE after edge n.
  - The next `irq` can assert after edge n+1 at the earliest, giving a minimum one-cycle `irq`-low gap.
- Mask write at edge j takes effect in arbitration from cycle j+1.
- Re-triggering the in-service source during SERV re-sets its pending bit; it is serviced after return.
- Reset asserted mid-REQ or mid-SERV drops `irq` immediately (asynchronously), without waiting for a clock.

## Test plan
- Reset with mask=0xFF and `irq_src`=0x00; pulse source 5 high at edge 10 → `pending`=0x20 after edge 10, `irq`=1 and `vec_id`=5 after edge 11; `iack`=1 at edge 14 → `irq`=0, `in_service`=1, `pending`=0x00; `iack`=0 at edge 20 → `in_service`=0.
- Sources 6 and 2 rise on the same edge → `vec_id`=2 first. After its ack/return, `irq` re-asserts with `vec_id`=6 exactly 2 edges after `iack` falls.
- mask=0x00 and source 3 rises → `pending`=0x08, `irq` stays 0. Write mask=0x08 → `irq`=1 with `vec_id`=3 one edge after the write.
- In REQ with `vec_id`=4, write mask=0x00 while `iack`=0 → `irq`=0 and state IDLE next edge; `pending[4]` is still 1.
- Source 1 rises on the same edge as `pend_clr`=0x02 → `pending[1]`=1 (set wins). Source 0 rises during REQ with `vec_id`=1 → `vec_id` stays 1 until ack.
- Assert `rst`=0 asynchronously between edges while in SERV with `pending`=0x81 → all outputs 0 immediately. After release with source 7 still high, `pending`=0x80 after the first edge.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter
// Collects rising edges from peripheral interrupt lines into a pending
// register, gates them with a software mask and offers one fixed-priority
// winner (lowest index) to the control FSM through a single irq/iack
// handshake. The granted source is tracked until the core returns.

module irq_arbiter #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_din,
   input  logic [N_SRC-1:0] pend_clr,
   input  logic             iack,
   output logic             irq,
   output logic [ID_W-1:0]  vec_id,
   output logic             in_service,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] mask
);

   // Handshake with the core: IDLE -> REQ (irq high) -> SERV (in service)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] pending_q;
   logic [N_SRC-1:0] pending_d;
   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] mask_d;
   logic [ID_W-1:0]  vec_id_q;
   logic [ID_W-1:0]  vec_id_d;
   logic             irq_q;
   logic             irq_d;
   logic             in_service_q;
   logic             in_service_d;

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] vecOneHot;
   logic [N_SRC-1:0] grantClr;
   logic [ID_W-1:0]  winner;
   logic             anyEligible;
   logic             vecEligible;

   // A source requests service only on its 0->1 transition; since src_q
   // clears in reset, a line held high through reset release counts as an
   // edge on the first clock.
   assign rise = irq_src & ~src_q;

   // Masked sources still collect pending bits, they just cannot win.
   assign eligible    = pending_q & mask_q;
   assign anyEligible = |eligible;

   // Fixed priority: scan from the top so the lowest set index is left last.
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = ID_W'(i);
         end
      end
   end

   // One-hot decode of the frozen vector id, used both to watch whether the
   // requested source is still eligible and to clear it on grant.
   always_comb begin
      vecOneHot = '0;
      for (int i = 0; i < N_SRC; i++) begin
         vecOneHot[i] = (vec_id_q == ID_W'(i));
      end
   end

   assign vecEligible = |(eligible & vecOneHot);

   // Next-state and registered-output decode for the irq/iack handshake.
   // The vector id is only ever loaded when leaving IDLE, so a later
   // higher-priority edge cannot preempt a request already on the bus.
   always_comb begin
      state_d  = state_q;
      vec_id_d = vec_id_q;
      grantClr = '0;

      unique case (state_q)
         IDLE: begin
            // iack high here belongs to a foreign entry; hold off until it drops
            if (anyEligible && !iack) begin
               state_d  = REQ;
               vec_id_d = winner;
            end
         end

         REQ: begin
            // Withdrawal by software is checked before the acknowledge
            if (!vecEligible && !iack) begin
               state_d = IDLE;
            end else if (iack) begin
               state_d  = SERV;
               grantClr = vecOneHot;
            end
         end

         SERV: begin
            if (!iack) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      irq_d        = (state_d == REQ);
      in_service_d = (state_d == SERV);
   end

   // Pending bits: a fresh edge always wins over a software or grant clear
   // landing in the same cycle, so no request is ever lost.
   always_comb begin
      pending_d = rise | (pending_q & ~pend_clr & ~grantClr);
   end

   // Mask register is software writable; it affects arbitration from the
   // cycle after the write.
   always_comb begin
      mask_d = mask_we ? mask_din : mask_q;
   end

   // Source history, pending and mask registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q     <= '0;
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         src_q     <= irq_src;
         pending_q <= pending_d;
         mask_q    <= mask_d;
      end
   end

   // FSM state plus the registered handshake outputs; reset drops irq at
   // once without waiting for a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         vec_id_q     <= '0;
         irq_q        <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_id_q     <= vec_id_d;
         irq_q        <= irq_d;
         in_service_q <= in_service_d;
      end
   end

   assign irq        = irq_q;
   assign vec_id     = vec_id_q;
   assign in_service = in_service_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Testbench for irq_arbiter: directed scenarios followed by randomized
// traffic. Every driven cycle is fed to a behavioural model whose predicted
// outputs are queued; an independent monitor pops and compares them one
// time unit after each rising edge.

module tb_irq_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] irqSrc;
   logic       maskWe;
   logic [7:0] maskDin;
   logic [7:0] pendClr;
   logic       iack;
   logic       irq;
   logic [2:0] vecId;
   logic       inService;
   logic [7:0] pending;
   logic [7:0] mask;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic       irq;
      logic [2:0] vec;
      logic       inServ;
      logic [7:0] pend;
      logic [7:0] mask;
   } expect_t;

   expect_t expQ[$];

   // Behavioural view of the arbiter: where the handshake is, which source
   // was offered, and the software-visible registers.
   localparam int M_IDLE = 0;
   localparam int M_REQ  = 1;
   localparam int M_SERV = 2;

   bit [7:0] mSrcPrev;
   bit [7:0] mPend;
   bit [7:0] mMask;
   int       mState;
   int       mVec;

   irq_arbiter #(.N_SRC(8), .ID_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_src    (irqSrc),
      .mask_we    (maskWe),
      .mask_din   (maskDin),
      .pend_clr   (pendClr),
      .iack       (iack),
      .irq        (irq),
      .vec_id     (vecId),
      .in_service (inService),
      .pending    (pending),
      .mask       (mask)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single place where a comparison is counted and reported
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int lowestSet(input bit [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // Advance the model by one clock using the inputs currently driven and
   // queue what the DUT should show after that edge.
   task automatic modelStep();
      bit [7:0] rise;
      bit [7:0] elig;
      bit [7:0] grant;
      expect_t  e;
      if (!rst) begin
         mSrcPrev = '0;
         mPend    = '0;
         mMask    = '0;
         mState   = M_IDLE;
         mVec     = 0;
      end else begin
         rise  = irqSrc & ~mSrcPrev;
         elig  = mPend & mMask;
         grant = '0;
         case (mState)
            M_IDLE: if (elig != 0 && !iack) begin
               mState = M_REQ;
               mVec   = lowestSet(elig);
            end
            M_REQ: if (!elig[mVec] && !iack) begin
               mState = M_IDLE;
            end else if (iack) begin
               mState      = M_SERV;
               grant[mVec] = 1'b1;
            end
            default: if (!iack) mState = M_IDLE;
         endcase
         mPend    = rise | (mPend & ~pendClr & ~grant);
         if (maskWe) mMask = maskDin;
         mSrcPrev = irqSrc;
      end
      e.irq    = (mState == M_REQ);
      e.vec    = 3'(mVec);
      e.inServ = (mState == M_SERV);
      e.pend   = mPend;
      e.mask   = mMask;
      expQ.push_back(e);
   endtask

   // Called at a falling edge: drive one cycle of inputs, predict, and
   // return at the next falling edge with the DUT outputs settled.
   task automatic applyStimulus(input logic [7:0] src, input logic we,
                                input logic [7:0] din, input logic [7:0] clr,
                                input logic ack);
      irqSrc  = src;
      maskWe  = we;
      maskDin = din;
      pendClr = clr;
      iack    = ack;
      modelStep();
      @(negedge clk);
   endtask

   // Pull reset between edges and verify outputs collapse without a clock
   task automatic applyReset(input logic [7:0] src);
      irqSrc  = src;
      maskWe  = 1'b0;
      maskDin = '0;
      pendClr = '0;
      iack    = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_irq", irq, 0);
      checkOutput("async_rst_vec", vecId, 0);
      checkOutput("async_rst_inserv", inService, 0);
      checkOutput("async_rst_pending", pending, 0);
      checkOutput("async_rst_mask", mask, 0);
      modelStep();
      @(negedge clk);
   endtask

   // Scoreboard monitor: compare every predicted cycle against the DUT
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sb_irq", irq, e.irq);
            checkOutput("sb_vec_id", vecId, e.vec);
            checkOutput("sb_in_service", inService, e.inServ);
            checkOutput("sb_pending", pending, e.pend);
            checkOutput("sb_mask", mask, e.mask);
         end
      end
   end

   // Directed scenarios first, then randomized traffic
   initial begin
      logic [7:0] rSrc;
      logic       rAck;
      logic       rWe;
      logic [7:0] rDin;
      logic [7:0] rClr;

      rst     = 1'b0;
      irqSrc  = '0;
      maskWe  = 1'b0;
      maskDin = '0;
      pendClr = '0;
      iack    = 1'b0;
      @(negedge clk);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      checkOutput("reset_irq", irq, 0);
      checkOutput("reset_pending", pending, 0);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      rst = 1'b1;

      // Single source request, acknowledge and return
      applyStimulus(8'h00, 1, 8'hFF, 8'h00, 0);
      checkOutput("mask_write_ff", mask, 8'hFF);
      repeat (3) applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      applyStimulus(8'h20, 0, 8'h00, 8'h00, 0);
      checkOutput("s5_pending", pending, 8'h20);
      checkOutput("s5_irq_not_yet", irq, 0);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      checkOutput("s5_irq", irq, 1);
      checkOutput("s5_vec", vecId, 5);
      repeat (2) applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      checkOutput("s5_req_held", irq, 1);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 1);
      checkOutput("s5_ack_irq", irq, 0);
      checkOutput("s5_ack_inserv", inService, 1);
      checkOutput("s5_ack_pending", pending, 8'h00);
      repeat (5) applyStimulus(8'h00, 0, 8'h00, 8'h00, 1);
      checkOutput("s5_serv_held", inService, 1);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      checkOutput("s5_return", inService, 0);

      // Simultaneous edges on sources 6 and 2
      applyStimulus(8'h44, 0, 8'h00, 8'h00, 0);
      checkOutput("dual_pending", pending, 8'h44);
      applyStimulus(8'h44, 0, 8'h00, 8'h00, 0);
      checkOutput("dual_first_vec", vecId, 2);
      applyStimulus(8'h44, 0, 8'h00, 8'h00, 1);
      checkOutput("dual_pending_after_ack", pending, 8'h40);
      applyStimulus(8'h44, 0, 8'h00, 8'h00, 1);
      applyStimulus(8'h44, 0, 8'h00, 8'h00, 0);
      checkOutput("dual_gap_irq", irq, 0);
      applyStimulus(8'h44, 0, 8'h00, 8'h00, 0);
      checkOutput("dual_second_irq", irq, 1);
      checkOutput("dual_second_vec", vecId, 6);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 1);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);

      // Masked source pends quietly until enabled
      applyStimulus(8'h00, 1, 8'h00, 8'h00, 0);
      applyStimulus(8'h08, 0, 8'h00, 8'h00, 0);
      checkOutput("masked_pending", pending, 8'h08);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      checkOutput("masked_no_irq", irq, 0);
      applyStimulus(8'h00, 1, 8'h08, 8'h00, 0);
      checkOutput("unmask_same_edge_irq", irq, 0);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      checkOutput("unmask_irq", irq, 1);
      checkOutput("unmask_vec", vecId, 3);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 1);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);

      // Request withdrawn by masking while in REQ
      applyStimulus(8'h00, 1, 8'hFF, 8'h00, 0);
      applyStimulus(8'h10, 0, 8'h00, 8'h00, 0);
      applyStimulus(8'h10, 0, 8'h00, 8'h00, 0);
      checkOutput("wd_vec", vecId, 4);
      applyStimulus(8'h10, 1, 8'h00, 8'h00, 0);
      applyStimulus(8'h10, 0, 8'h00, 8'h00, 0);
      checkOutput("wd_irq_dropped", irq, 0);
      checkOutput("wd_pending_kept", pending, 8'h10);
      applyStimulus(8'h00, 0, 8'h00, 8'h10, 0);
      checkOutput("wd_pending_cleared", pending, 8'h00);

      // Edge beats clear; no preemption while in REQ
      applyStimulus(8'h00, 1, 8'hFF, 8'h00, 0);
      applyStimulus(8'h02, 0, 8'h00, 8'h02, 0);
      checkOutput("set_wins_pending", pending, 8'h02);
      applyStimulus(8'h02, 0, 8'h00, 8'h00, 0);
      applyStimulus(8'h03, 0, 8'h00, 8'h00, 0);
      checkOutput("nopreempt_pending", pending, 8'h03);
      applyStimulus(8'h03, 0, 8'h00, 8'h00, 0);
      checkOutput("nopreempt_vec", vecId, 1);
      applyStimulus(8'h03, 0, 8'h00, 8'h00, 1);
      checkOutput("nopreempt_serv_vec", vecId, 1);
      applyStimulus(8'h03, 0, 8'h00, 8'h00, 0);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);
      checkOutput("src0_after_return", vecId, 0);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 1);
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 0);

      // Retrigger during service, then asynchronous reset mid-SERV
      applyStimulus(8'h81, 0, 8'h00, 8'h00, 0);
      applyStimulus(8'h81, 0, 8'h00, 8'h00, 0);
      applyStimulus(8'h81, 0, 8'h00, 8'h00, 1);
      applyStimulus(8'h80, 0, 8'h00, 8'h00, 1);
      applyStimulus(8'h81, 0, 8'h00, 8'h00, 1);
      checkOutput("retrig_pending", pending, 8'h81);
      checkOutput("retrig_inserv", inService, 1);
      applyReset(8'h81);
      rst = 1'b1;
      applyStimulus(8'h80, 0, 8'h00, 8'h00, 0);
      checkOutput("post_rst_pending", pending, 8'h80);

      // Randomized traffic with a core that acknowledges with random delay
      rSrc = 8'h80;
      rAck = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 1500) begin
            applyReset(rSrc);
            rst = 1'b1;
            rAck = 1'b0;
         end
         rSrc = rSrc ^ 8'($urandom & $urandom & $urandom);
         rWe  = ($urandom_range(0, 15) == 0);
         rDin = 8'($urandom);
         rClr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         if (mState == M_REQ && !rAck)      rAck = ($urandom_range(0, 1) == 1);
         else if (rAck)                     rAck = ($urandom_range(0, 3) != 0);
         else                               rAck = ($urandom_range(0, 31) == 0);
         applyStimulus(rSrc, rWe, rDin, rClr, rAck);
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
